// File: rtl/multiplication_pkg.sv
// multiplication_pkg: state encoding and sizing constants shared by the iterative multiply and divide units.
package multiplication_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int WIDTH_DEFAULT = 8;
    function automatic int count_width(input int w);
        return $clog2(w) + 1;
    endfunction
    localparam int CNT_W = count_width(WIDTH_DEFAULT);
endpackage

// File: rtl/multiplication.sv
// multiplication: sequential shift-add multiply-accumulate, product = num1*num2 + addend,
// started by a rising edge on multiplication_wakeup and finished with a one-cycle done pulse.
module multiplication
    import multiplication_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [WIDTH-1:0]   num1,
    input  logic [WIDTH-1:0]   num2,
    input  logic [WIDTH-1:0]   addend,
    input  logic               multiplication_wakeup,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = count_width(WIDTH);
    state_t             state;
    logic               wakeup_q;
    logic [2*WIDTH-1:0] acc, mcand, acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               start;
    assign start    = multiplication_wakeup && !wakeup_q && state == IDLE;
    assign acc_next = mplier[0] ? acc + mcand : acc;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            wakeup_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
        end else begin
            wakeup_q <= multiplication_wakeup;
            done     <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    acc    <= {{WIDTH{1'b0}}, addend};
                    mcand  <= {{WIDTH{1'b0}}, num1};
                    mplier <= num2;
                    count  <= '0;
                    busy   <= 1'b1;
                    state  <= CALC;
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        product <= acc_next;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
